peg_l2_rmii_phy_rx: RTL



---
 rtl/peg_l2_rmii_pkg.sv | 21 ++
 rtl/peg_l2_rmii_rate_tick.sv | 34 +++
 rtl/peg_l2_rmii_phy_rx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/peg_l2_rmii_pkg.sv
// Shared types and constants for the PHY-side RMII receive driver and its rate tick generator.
package peg_l2_rmii_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StIfg,
    StUnderrun
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned RMII_10M_DIV  = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/peg_l2_rmii_rate_tick.sv
// 10/100 dibit tick generator: speed is re-latched while i_latch is high, and a speed change
// restarts the 0..9 divider so the first 10M dibit is a full period.
module peg_l2_rmii_rate_tick
  import peg_l2_rmii_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_speed_100,
  input  logic i_latch,
  output logic o_tick
);

  logic       r_speed_100;
  logic [3:0] r_cnt;
  logic       w_relatch;
  logic       w_wrap;

  assign w_relatch = i_latch && (i_speed_100 != r_speed_100);
  assign w_wrap    = (r_cnt == 4'(RMII_10M_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_speed_100 <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (i_latch) r_speed_100 <= i_speed_100;
      if (w_relatch || w_wrap) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_tick = r_speed_100 || w_wrap;

endmodule

// File: rtl/peg_l2_rmii_phy_rx.sv
// PHY-side RMII receive driver: turns a byte stream into RXD/CRS_DV/RX_ER dibits toward a MAC.
// Define PEG_RMII_PHY_PREAMBLE_GEN_EN to generate preamble and SFD; otherwise they come in-band.
module peg_l2_rmii_phy_rx
  import peg_l2_rmii_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned IFG_BYTES      = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_speed_100,
  input  logic       i_pkt_valid,
  input  logic       i_pkt_sop,
  input  logic       i_pkt_eop,
  input  logic       i_pkt_err,
  input  logic [7:0] i_pkt_data,
  output logic       o_pkt_ready,
  output logic [1:0] o_rmii_rxd,
  output logic       o_rmii_crs_dv,
  output logic       o_rmii_rx_er,
  output logic       o_underrun_pulse
);

  localparam int unsigned CntMax = max_u(PREAMBLE_BYTES * 4, IFG_BYTES * 4);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [5:0]        r_shift, w_shift_d;
  logic              r_eop_byte, w_eop_byte_d;
  logic              r_drop, w_drop_d;
  logic              r_hold_vld, w_hold_vld_d;
  logic              r_hold_sop, r_hold_eop, r_hold_err;
  logic [7:0]        r_hold_data;
  logic              r_ready;
  logic [1:0]        r_rxd, w_rxd_d;
  logic              r_crs_dv, w_crs_dv_d;
  logic              r_rx_er, w_rx_er_d;
  logic              r_pulse, w_pulse_d;

  logic w_tick, w_accept, w_take, w_hold_sof;
  logic w_start, w_load, w_urun, w_to_ifg;

  peg_l2_rmii_rate_tick u_rate_tick (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_speed_100 (i_speed_100),
    .i_latch     (r_state == StIdle),
    .o_tick      (w_tick)
  );

  assign w_accept   = i_pkt_valid && r_ready;
  assign w_hold_sof = r_hold_vld && r_hold_sop && !r_drop;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_shift_d    = r_shift;
    w_eop_byte_d = r_eop_byte;
    w_drop_d     = r_drop;
    w_rxd_d      = r_rxd;
    w_crs_dv_d   = r_crs_dv;
    w_rx_er_d    = r_rx_er;
    w_pulse_d    = 1'b0;
    w_take       = 1'b0;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_urun       = 1'b0;
    w_to_ifg     = 1'b0;

    if (w_tick) begin
      unique case (r_state)
        StIdle: w_start = w_hold_sof;
`ifdef PEG_RMII_PHY_PREAMBLE_GEN_EN
        StPreamble: begin
          if (r_cnt == CntW'(PREAMBLE_BYTES * 4 - 1)) begin
            w_state_d = StSfd;
            w_cnt_d   = '0;
            w_rxd_d   = SFD_BYTE[1:0];
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        // The sop byte has sat in hold since IDLE; it is the first DATA byte.
        StSfd: begin
          if (r_cnt == CntW'(3)) begin
            w_load = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
            w_rxd_d = SFD_BYTE[{r_cnt[1:0] + 2'd1, 1'b0} +: 2];
          end
        end
`endif
        StData: begin
          if (r_cnt == CntW'(3)) begin
            if (r_eop_byte)                      w_to_ifg = 1'b1;
            else if (r_hold_vld && !r_hold_sop)  w_load   = 1'b1;
            else                                 w_urun   = 1'b1;
          end else begin
            w_cnt_d   = r_cnt + CntW'(1);
            w_rxd_d   = r_shift[1:0];
            w_shift_d = {2'b00, r_shift[5:2]};
          end
        end
        StUnderrun: begin
          if (r_cnt == CntW'(3)) w_to_ifg = 1'b1;
          else                   w_cnt_d  = r_cnt + CntW'(1);
        end
        StIfg: begin
          if (r_cnt == CntW'(IFG_BYTES * 4 - 1)) begin
            // A waiting frame starts straight out of IFG so the gap is exactly IFG_BYTES.
            if (w_hold_sof) w_start   = 1'b1;
            else            w_state_d = StIdle;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    if (w_start) begin
`ifdef PEG_RMII_PHY_PREAMBLE_GEN_EN
      w_state_d  = StPreamble;
      w_cnt_d    = '0;
      w_rxd_d    = PREAMBLE_BYTE[1:0];
      w_crs_dv_d = 1'b1;
      w_rx_er_d  = 1'b0;
`else
      w_load = 1'b1;
`endif
    end

    if (w_load) begin
      w_take       = 1'b1;
      w_state_d    = StData;
      w_cnt_d      = '0;
      w_rxd_d      = r_hold_data[1:0];
      w_shift_d    = r_hold_data[7:2];
      w_eop_byte_d = r_hold_eop;
      w_crs_dv_d   = 1'b1;
      w_rx_er_d    = r_hold_err;
    end

    if (w_urun) begin
      w_state_d  = StUnderrun;
      w_cnt_d    = '0;
      w_rxd_d    = 2'b00;
      w_crs_dv_d = 1'b1;
      w_rx_er_d  = 1'b1;
      w_pulse_d  = 1'b1;
      w_take     = r_hold_vld;
      w_drop_d   = !(r_hold_vld && r_hold_eop);
    end

    if (w_to_ifg) begin
      w_state_d  = StIfg;
      w_cnt_d    = '0;
      w_rxd_d    = 2'b00;
      w_crs_dv_d = 1'b0;
      w_rx_er_d  = 1'b0;
    end

    // Discards run every clock, independent of the dibit tick.
    if (r_hold_vld && !w_take) begin
      if (r_drop) begin
        w_take = 1'b1;
        if (r_hold_eop) w_drop_d = 1'b0;
      end else if ((r_state == StIdle || r_state == StIfg) && !r_hold_sop) begin
        w_take = 1'b1;
      end
    end

    w_hold_vld_d = r_hold_vld;
    if (w_take)   w_hold_vld_d = 1'b0;
    if (w_accept) w_hold_vld_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_eop_byte  <= 1'b0;
      r_drop      <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_sop  <= 1'b0;
      r_hold_eop  <= 1'b0;
      r_hold_err  <= 1'b0;
      r_hold_data <= '0;
      r_ready     <= 1'b0;
      r_rxd       <= 2'b00;
      r_crs_dv    <= 1'b0;
      r_rx_er     <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_shift    <= w_shift_d;
      r_eop_byte <= w_eop_byte_d;
      r_drop     <= w_drop_d;
      r_hold_vld <= w_hold_vld_d;
      if (w_accept) begin
        r_hold_sop  <= i_pkt_sop;
        r_hold_eop  <= i_pkt_eop;
        r_hold_err  <= i_pkt_err;
        r_hold_data <= i_pkt_data;
      end
      r_ready  <= !w_hold_vld_d;
      r_rxd    <= w_rxd_d;
      r_crs_dv <= w_crs_dv_d;
      r_rx_er  <= w_rx_er_d;
      r_pulse  <= w_pulse_d;
    end
  end

  assign o_pkt_ready      = r_ready;
  assign o_rmii_rxd       = r_rxd;
  assign o_rmii_crs_dv    = r_crs_dv;
  assign o_rmii_rx_er     = r_rx_er;
  assign o_underrun_pulse = r_pulse;

endmodule
